dma_transfer_ctrl: RTL and testbench
====================================

Name: dma_transfer_ctrl

Overview:
- Sequencing engine for the DMA register block. Takes the programmed source address, destination address, count and control bits.
- Moves `cfg_count` words from source to destination, one beat at a time, over separate read and write req/ack memory ports.
- Reports `busy`, `done`, `aborted` and remaining count back toward the CPU-visible status path.

Parameters:
- ADDR_W, 32, address width of both memory ports and the address config inputs
- DATA_W, 32, data word width
- CNT_W, 32, width of the transfer count
- TIMEOUT_CYC, 256, ack watchdog limit in cycles (used only with the optional feature)

Ports:
- clk  in  1  system clock, rising edge
- reset  in  1  asynchronous, active-high reset
- cfg_en  in  1  control register bit 0; a rising edge starts a transfer; low requests an abort
- cfg_inc_src  in  1  control bit 2; 1 = increment source address per beat, 0 = fixed (streaming)
- cfg_inc_dstn  in  1  control bit 3; 1 = increment destination address per beat, 0 = fixed
- cfg_src_addr  in  ADDR_W  programmed source base
- cfg_dstn_addr  in  ADDR_W  programmed destination base
- cfg_count  in  CNT_W  number of words to move
- rd_req  out  1  read request
- rd_addr  out  ADDR_W  read address
- rd_ack  in  1  read accepted; `rd_data` valid this cycle
- rd_data  in  DATA_W  read data
- wr_req  out  1  write request
- wr_addr  out  ADDR_W  write address
- wr_data  out  DATA_W  write data
- wr_ack  in  1  write accepted
- busy  out  1  high in every state except IDLE
- done  out  1  one-cycle completion pulse
- aborted  out  1  sticky; set when a transfer ends early, cleared on the next start
- remaining  out  CNT_W  words left in the current transfer

Behaviour:
- Reset (async, active-high):
  - state = IDLE
  - all outputs 0, including `rd_addr`, `wr_addr`, `wr_data` and `remaining`
  - `en_q` = 0; working registers = 0
- Start detection:
  - `en_q` registers `cfg_en` every cycle.
  - start = `cfg_en` & ~`en_q`, evaluated only in IDLE.
  - `cfg_en` held high through reset release is a start on the first clock.
- States:
  - IDLE: on start with `cfg_count` != 0, go to LOAD and clear `aborted`. On start with `cfg_count` == 0, go to DONE with no bus activity.
  - LOAD (1 cycle): latch `cur_src` = `cfg_src_addr`, `cur_dst` = `cfg_dstn_addr`, `remaining` = `cfg_count`, and both inc bits. Go to READ. Config inputs are ignored from here until IDLE.
  - READ:
    - `rd_req` = 1 with `rd_addr` = `cur_src`, held stable until `rd_ack`.
    - On `rd_ack`: capture `rd_data` into `wr_data`, go to WRITE.
  - WRITE:
    - `wr_req` = 1 with `wr_addr` = `cur_dst`, held until `wr_ack`.
    - On `wr_ack`: `remaining` -= 1; `cur_src` += `inc_src`; `cur_dst` += `inc_dstn`. Address adds are modulo 2^ADDR_W and wrap silently.
    - If the new `remaining` == 0, go to DONE.
    - Else if `cfg_en` == 0, set `aborted` and go to DONE.
    - Else go to READ.
  - DONE: `done` = 1 for exactly one cycle, then IDLE.
- Handshakes:
  - A request is never withdrawn before its ack, except by reset or timeout.
  - `rd_req` and `wr_req` are never high together.
  - An ack arriving while its req is low is ignored.
- Abort granularity:
  - Abort is taken only at a beat boundary; the in-flight read/write pair always completes.
  - `cfg_en` dropping in READ still completes that beat's write.
- Latency:
  - Start edge sampled at cycle N; LOAD at N+1; first `rd_req` at N+2.
  - With zero-wait acks, each beat takes 2 cycles.
  - `done` falls in cycle N+2+2C for count C.
- Arithmetic: `remaining` never underflows; the zero check precedes any further decrement.
- Reset mid-transfer: immediate return to IDLE with all outputs 0; no `done` pulse.

Optional Feature:
- Macro: DMA_ACK_TIMEOUT_EN
- With the macro defined:
  - A wait counter clears on entry to READ/WRITE and increments each cycle without an ack.
  - When it reaches TIMEOUT_CYC, the active req is dropped, `aborted` is set, and the state goes to DONE.
  - `remaining` keeps the value of the unfinished beat.
- Without the macro: no counter exists; the controller waits for an ack indefinitely.

Test Plan:
- src=0x100, dst=0x200, count=4, inc both, zero-wait acks -> reads 0x100..0x103, writes 0x200..0x203 with matching data. `done` pulse at cycle N+10; `remaining` = 0; `aborted` = 0.
- Fixed-address streaming, inc_src=0, inc_dstn=1, count=3 -> `rd_addr` stays 0x100 for all beats; `wr_addr` goes 0x200, 0x201, 0x202.
- count=0 start -> no `rd_req`/`wr_req` ever; `done` pulse at N+1; `busy` high for 1 cycle.
- count=8; drop `cfg_en` during the 3rd beat's READ with ack delayed 5 cycles -> beat 3 write completes. Then `done` and `aborted` = 1, with `remaining` = 5.
- src=0xFFFFFFFF, count=2, inc_src=1 -> second `rd_addr` = 0x00000000 (wrap). Also, with `wr_ack` stalled 3 cycles, `wr_req`, `wr_addr` and `wr_data` stay stable throughout the stall.
- With DMA_ACK_TIMEOUT_EN and TIMEOUT_CYC=16, `rd_ack` never asserted -> `rd_req` drops after 16 cycles, `done` pulses, `aborted` = 1, `remaining` = count. Reset asserted mid-WRITE -> all outputs 0 asynchronously and no `done` pulse.

Source files
------------

// File: rtl/dma_transfer_ctrl.sv
// dma_transfer_ctrl: single-channel DMA sequencer. Moves cfg_count words
// from a source to a destination over separate read and write req/ack
// ports, one beat (read then write) at a time.
// Optional build macro: DMA_ACK_TIMEOUT_EN adds an ack watchdog of
// TIMEOUT_CYC cycles on both ports; without it the controller waits for
// an ack indefinitely.
module dma_transfer_ctrl #(
  parameter int unsigned ADDR_W      = 32,
  parameter int unsigned DATA_W      = 32,
  parameter int unsigned CNT_W       = 32,
  parameter int unsigned TIMEOUT_CYC = 256
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              cfg_en,
  input  logic              cfg_inc_src,
  input  logic              cfg_inc_dstn,
  input  logic [ADDR_W-1:0] cfg_src_addr,
  input  logic [ADDR_W-1:0] cfg_dstn_addr,
  input  logic [CNT_W-1:0]  cfg_count,
  output logic              rd_req,
  output logic [ADDR_W-1:0] rd_addr,
  input  logic              rd_ack,
  input  logic [DATA_W-1:0] rd_data,
  output logic              wr_req,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [DATA_W-1:0] wr_data,
  input  logic              wr_ack,
  output logic              busy,
  output logic              done,
  output logic              aborted,
  output logic [CNT_W-1:0]  remaining
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_READ,
    S_WRITE,
    S_DONE
  } state_t;

  state_t              state_q, state_d;
  logic                en_q;
  logic [ADDR_W-1:0]   src_q, src_d;
  logic [ADDR_W-1:0]   dst_q, dst_d;
  logic [CNT_W-1:0]    rem_q, rem_d;
  logic                inc_src_q, inc_src_d;
  logic                inc_dst_q, inc_dst_d;
  logic [DATA_W-1:0]   wdata_q, wdata_d;
  logic                aborted_q, aborted_d;

  logic                start;
  logic [CNT_W-1:0]    rem_dec;
  logic                timeout;

  assign start   = cfg_en & ~en_q;
  assign rem_dec = rem_q - CNT_W'(1);

`ifdef DMA_ACK_TIMEOUT_EN
  localparam int unsigned WAIT_W = $clog2(TIMEOUT_CYC) + 1;

  logic [WAIT_W-1:0] wait_q, wait_d;

  // Watchdog fires on the TIMEOUT_CYC-th consecutive cycle without an ack,
  // so the request is visible for exactly TIMEOUT_CYC cycles.
  assign timeout = (((state_q == S_READ)  && !rd_ack) ||
                    ((state_q == S_WRITE) && !wr_ack)) &&
                   (wait_q == WAIT_W'(TIMEOUT_CYC - 1));

  // Wait counter: restarts on every state change, counts while a req waits.
  always_comb begin
    wait_d = '0;
    if (((state_q == S_READ) || (state_q == S_WRITE)) && (state_d == state_q))
      wait_d = wait_q + WAIT_W'(1);
  end

  // Wait counter register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) wait_q <= '0;
    else       wait_q <= wait_d;
  end
`else
  logic [31:0] unused_timeout_cyc;

  assign timeout            = 1'b0;
  assign unused_timeout_cyc = 32'(TIMEOUT_CYC);
`endif

  // Next-state and datapath update for the transfer sequencer.
  always_comb begin
    state_d   = state_q;
    src_d     = src_q;
    dst_d     = dst_q;
    rem_d     = rem_q;
    inc_src_d = inc_src_q;
    inc_dst_d = inc_dst_q;
    wdata_d   = wdata_q;
    aborted_d = aborted_q;

    case (state_q)
      S_IDLE: begin
        if (start) begin
          if (cfg_count != '0) begin
            state_d   = S_LOAD;
            aborted_d = 1'b0;
          end else begin
            state_d   = S_DONE;
          end
        end
      end

      S_LOAD: begin
        src_d     = cfg_src_addr;
        dst_d     = cfg_dstn_addr;
        rem_d     = cfg_count;
        inc_src_d = cfg_inc_src;
        inc_dst_d = cfg_inc_dstn;
        state_d   = S_READ;
      end

      S_READ: begin
        if (rd_ack) begin
          wdata_d = rd_data;
          state_d = S_WRITE;
        end else if (timeout) begin
          aborted_d = 1'b1;
          state_d   = S_DONE;
        end
      end

      S_WRITE: begin
        if (wr_ack) begin
          rem_d = rem_dec;
          src_d = src_q + ADDR_W'(inc_src_q);
          dst_d = dst_q + ADDR_W'(inc_dst_q);
          // Completion wins over abort: a last beat finishing with cfg_en low
          // is a normal end, not an early one.
          if (rem_dec == '0) begin
            state_d = S_DONE;
          end else if (!cfg_en) begin
            aborted_d = 1'b1;
            state_d   = S_DONE;
          end else begin
            state_d = S_READ;
          end
        end else if (timeout) begin
          aborted_d = 1'b1;
          state_d   = S_DONE;
        end
      end

      S_DONE: begin
        state_d = S_IDLE;
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // State and working registers; everything clears on async reset.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= S_IDLE;
      en_q      <= 1'b0;
      src_q     <= '0;
      dst_q     <= '0;
      rem_q     <= '0;
      inc_src_q <= 1'b0;
      inc_dst_q <= 1'b0;
      wdata_q   <= '0;
      aborted_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      en_q      <= cfg_en;
      src_q     <= src_d;
      dst_q     <= dst_d;
      rem_q     <= rem_d;
      inc_src_q <= inc_src_d;
      inc_dst_q <= inc_dst_d;
      wdata_q   <= wdata_d;
      aborted_q <= aborted_d;
    end
  end

  assign rd_req    = (state_q == S_READ);
  assign wr_req    = (state_q == S_WRITE);
  assign rd_addr   = src_q;
  assign wr_addr   = dst_q;
  assign wr_data   = wdata_q;
  assign busy      = (state_q != S_IDLE);
  assign done      = (state_q == S_DONE);
  assign aborted   = aborted_q;
  assign remaining = rem_q;

endmodule

// File: tb/tb_dma_transfer_ctrl.sv
// Testbench for dma_transfer_ctrl: directed and randomized transfers against
// a memory responder; expected beats are computed from base/increment/count
// arithmetic and a hashed memory image.
module tb_dma_transfer_ctrl;

  localparam int unsigned TO = 16;

  logic        clk = 1'b0;
  logic        reset;
  logic        cfg_en, cfg_inc_src, cfg_inc_dstn;
  logic [31:0] cfg_src_addr, cfg_dstn_addr, cfg_count;
  logic        rd_req, rd_ack, wr_req, wr_ack;
  logic [31:0] rd_addr, rd_data, wr_addr, wr_data;
  logic        busy, done, aborted;
  logic [31:0] remaining;

  dma_transfer_ctrl #(
    .ADDR_W      (32),
    .DATA_W      (32),
    .CNT_W       (32),
    .TIMEOUT_CYC (TO)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .cfg_en        (cfg_en),
    .cfg_inc_src   (cfg_inc_src),
    .cfg_inc_dstn  (cfg_inc_dstn),
    .cfg_src_addr  (cfg_src_addr),
    .cfg_dstn_addr (cfg_dstn_addr),
    .cfg_count     (cfg_count),
    .rd_req        (rd_req),
    .rd_addr       (rd_addr),
    .rd_ack        (rd_ack),
    .rd_data       (rd_data),
    .wr_req        (wr_req),
    .wr_addr       (wr_addr),
    .wr_data       (wr_data),
    .wr_ack        (wr_ack),
    .busy          (busy),
    .done          (done),
    .aborted       (aborted),
    .remaining     (remaining)
  );

  always #5 clk = ~clk;

  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int unsigned errors = 0, checks = 0;
  int unsigned rd_lat, wr_lat, rd_wait, wr_wait;
  int unsigned rd_starts, busy_cnt, done_cnt, done_cyc, req_cnt, proto_err;
  bit          rd_never, wr_never, proto_on;
  logic        rd_req_prev, wr_req_prev;
  logic [31:0] rd_addr_prev, wr_addr_prev, wr_data_prev;
  logic [31:0] obs_rd[$], obs_wa[$], obs_wd[$];
  logic [31:0] seed;

  // Memory image: a hash of the address, reseeded per transfer.
  function automatic logic [31:0] memf(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ seed;
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic clear_obs();
    obs_rd.delete(); obs_wa.delete(); obs_wd.delete();
    rd_starts = 0; busy_cnt = 0; done_cnt = 0; done_cyc = 0;
    req_cnt = 0; proto_err = 0;
  endtask

  // One clock: observe at the falling edge, then act as the memory responder.
  task automatic tick();
    @(negedge clk);
    if (busy) busy_cnt++;
    if (done) begin
      if (done_cnt == 0) done_cyc = cyc;
      done_cnt++;
    end
    if (rd_req || wr_req) req_cnt++;
    if (rd_req && wr_req) proto_err++;
    if (rd_req && !rd_req_prev) rd_starts++;
    if (proto_on && rd_req_prev && !rd_ack)
      if (!rd_req || rd_addr !== rd_addr_prev) proto_err++;
    if (proto_on && wr_req_prev && !wr_ack)
      if (!wr_req || wr_addr !== wr_addr_prev || wr_data !== wr_data_prev) proto_err++;
    if (rd_ack) begin
      rd_ack = 1'b0; rd_wait = 0;
    end else if (rd_req && !rd_never) begin
      if (rd_wait >= rd_lat) begin
        rd_ack = 1'b1; rd_data = memf(rd_addr); obs_rd.push_back(rd_addr);
      end else rd_wait++;
    end
    if (wr_ack) begin
      wr_ack = 1'b0; wr_wait = 0;
    end else if (wr_req && !wr_never) begin
      if (wr_wait >= wr_lat) begin
        wr_ack = 1'b1; obs_wa.push_back(wr_addr); obs_wd.push_back(wr_data);
      end else wr_wait++;
    end
    rd_req_prev = rd_req; rd_addr_prev = rd_addr;
    wr_req_prev = wr_req; wr_addr_prev = wr_addr; wr_data_prev = wr_data;
  endtask

  // Wait for completion and compare every beat with the reference sequence.
  task automatic expect_done(input logic [31:0] src, input logic [31:0] dst,
                             input logic [31:0] cnt, input bit is, input bit id,
                             input int unsigned ab, input bit lat_chk,
                             input int unsigned n0, input string tag);
    int unsigned beats, n;
    bit          ab_exp;
    logic [31:0] ea;
    for (int k = 0; k < 4000 && done_cnt == 0; k++) begin
      tick();
      if (ab != 0 && rd_starts == ab && rd_req) cfg_en = 1'b0;
      if (rd_starts != 0) begin
        cfg_src_addr = $urandom; cfg_dstn_addr = $urandom; cfg_count = $urandom;
        cfg_inc_src = ~is; cfg_inc_dstn = ~id;
      end
    end
    tick(); tick();
    chk({tag, "_done_pulses"}, done_cnt, 1);
    ab_exp = (ab != 0) && (ab < cnt);
    beats  = ab_exp ? ab : cnt;
    chk({tag, "_reads"},  obs_rd.size(), beats);
    chk({tag, "_writes"}, obs_wa.size(), beats);
    n = beats;
    if (obs_rd.size() < n) n = obs_rd.size();
    if (obs_wa.size() < n) n = obs_wa.size();
    for (int k = 0; k < int'(n); k++) begin
      ea = src + (is ? 32'(k) : 32'd0);
      chk($sformatf("%s_rd_addr%0d", tag, k), obs_rd[k], ea);
      chk($sformatf("%s_wr_addr%0d", tag, k), obs_wa[k], dst + (id ? 32'(k) : 32'd0));
      chk($sformatf("%s_wr_data%0d", tag, k), obs_wd[k], memf(ea));
    end
    chk({tag, "_remaining"}, remaining, cnt - beats);
    chk({tag, "_aborted"},   aborted,   ab_exp);
    chk({tag, "_busy_end"},  busy,      1'b0);
    chk({tag, "_protocol"},  proto_err, 0);
    if (lat_chk) chk({tag, "_latency"}, done_cyc - n0, (cnt == 0) ? 1 : 2 + 2 * cnt);
  endtask

  task automatic run(input logic [31:0] src, input logic [31:0] dst, input logic [31:0] cnt,
                     input bit is, input bit id, input int unsigned rl, input int unsigned wl,
                     input int unsigned ab, input bit lat_chk, input string tag);
    int unsigned n0;
    cfg_en = 1'b0;
    tick(); tick();
    cfg_src_addr = src; cfg_dstn_addr = dst; cfg_count = cnt;
    cfg_inc_src = is; cfg_inc_dstn = id;
    rd_lat = rl; wr_lat = wl; seed = $urandom;
    clear_obs();
    cfg_en = 1'b1; n0 = cyc;
    expect_done(src, dst, cnt, is, id, ab, lat_chk, n0, tag);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int unsigned n0;
    logic [31:0] s, d, c;
    bit          bi, bd;
    int unsigned rl, wl;

    reset = 1'b1; cfg_en = 1'b1; cfg_inc_src = 1'b1; cfg_inc_dstn = 1'b1;
    cfg_src_addr = 32'h40; cfg_dstn_addr = 32'h80; cfg_count = 32'd1;
    rd_ack = 1'b0; wr_ack = 1'b0; rd_data = '0;
    rd_lat = 0; wr_lat = 0; rd_wait = 0; wr_wait = 0;
    rd_never = 1'b0; wr_never = 1'b0; proto_on = 1'b1;
    rd_req_prev = 1'b0; wr_req_prev = 1'b0;
    rd_addr_prev = '0; wr_addr_prev = '0; wr_data_prev = '0;
    seed = $urandom;
    clear_obs();

    #12;
    chk("rst_rd_req", rd_req, 1'b0);
    chk("rst_wr_req", wr_req, 1'b0);
    chk("rst_rd_addr", rd_addr, 32'h0);
    chk("rst_wr_addr", wr_addr, 32'h0);
    chk("rst_wr_data", wr_data, 32'h0);
    chk("rst_busy", busy, 1'b0);
    chk("rst_done", done, 1'b0);
    chk("rst_aborted", aborted, 1'b0);
    chk("rst_remaining", remaining, 32'h0);

    // cfg_en held high through reset release starts on the first clock
    @(negedge clk);
    reset = 1'b0; n0 = cyc;
    expect_done(32'h40, 32'h80, 32'd1, 1'b1, 1'b1, 0, 1'b1, n0, "por");

    run(32'h100, 32'h200, 32'd4, 1'b1, 1'b1, 0, 0, 0, 1'b1, "basic");

    run(32'h300, 32'h400, 32'd0, 1'b1, 1'b1, 0, 0, 0, 1'b1, "zero");
    chk("zero_req_cycles", req_cnt, 0);
    chk("zero_busy_cycles", busy_cnt, 1);

    run(32'h100, 32'h200, 32'd3, 1'b0, 1'b1, 0, 0, 0, 1'b1, "stream");

    run(32'hFFFF_FFFF, 32'h500, 32'd2, 1'b1, 1'b1, 0, 3, 0, 1'b0, "wrap");
    chk("wrap_second_rd_addr", (obs_rd.size() > 1) ? obs_rd[1] : 32'hDEAD_BEEF, 32'h0);

    run(32'h1000, 32'h2000, 32'd8, 1'b1, 1'b1, 5, 0, 3, 1'b0, "abort");

    for (int i = 0; i < 6; i++) begin
      s = $urandom; d = $urandom; c = $urandom_range(1, 6);
      bi = 1'($urandom); bd = 1'($urandom);
      rl = $urandom_range(0, 3); wl = $urandom_range(0, 3);
      run(s, d, c, bi, bd, rl, wl, 0, (rl == 0 && wl == 0), $sformatf("rand%0d", i));
    end

`ifdef DMA_ACK_TIMEOUT_EN
    cfg_en = 1'b0; tick(); tick();
    cfg_src_addr = 32'h700; cfg_dstn_addr = 32'h800; cfg_count = 32'd5;
    cfg_inc_src = 1'b1; cfg_inc_dstn = 1'b1;
    rd_never = 1'b1; proto_on = 1'b0; clear_obs();
    cfg_en = 1'b1;
    for (int k = 0; k < 200 && done_cnt == 0; k++) tick();
    tick(); tick();
    chk("to_req_cycles", req_cnt, TO);
    chk("to_done_pulses", done_cnt, 1);
    chk("to_aborted", aborted, 1'b1);
    chk("to_remaining", remaining, 32'd5);
    chk("to_writes", obs_wa.size(), 0);
    rd_never = 1'b0; proto_on = 1'b1;
`endif

    // Reset while a write is stalled: outputs clear at once, no done pulse.
    cfg_en = 1'b0; tick(); tick();
    cfg_src_addr = 32'h900; cfg_dstn_addr = 32'hA00; cfg_count = 32'd4;
    cfg_inc_src = 1'b1; cfg_inc_dstn = 1'b1;
    rd_lat = 0; wr_never = 1'b1; proto_on = 1'b0; seed = $urandom; clear_obs();
    cfg_en = 1'b1;
    for (int k = 0; k < 100 && !wr_req; k++) tick();
    chk("mrst_reached_write", wr_req, 1'b1);
    #2 reset = 1'b1;
    #1;
    chk("mrst_wr_req", wr_req, 1'b0);
    chk("mrst_rd_req", rd_req, 1'b0);
    chk("mrst_busy", busy, 1'b0);
    chk("mrst_done", done, 1'b0);
    chk("mrst_wr_addr", wr_addr, 32'h0);
    chk("mrst_wr_data", wr_data, 32'h0);
    chk("mrst_rd_addr", rd_addr, 32'h0);
    chk("mrst_remaining", remaining, 32'h0);
    chk("mrst_aborted", aborted, 1'b0);
    cfg_en = 1'b0;
    tick(); tick();
    reset = 1'b0;
    tick(); tick(); tick();
    chk("mrst_no_done", done_cnt, 0);
    chk("mrst_idle", busy, 1'b0);
    wr_never = 1'b0; proto_on = 1'b1;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
